// File: rtl/gba_cart_bus_ctrl.sv
// Game Pak bus sequencer: turns one 16/32-bit request into timed cartridge
// cycles. The first halfword is nonsequential (N_WAIT waits) and the second
// halfword of a word is sequential (S_WAIT waits). Strobes are active-high.
module gba_cart_bus_ctrl #(
  parameter int N_WAIT = 4,
  parameter int S_WAIT = 2
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [24:0] req_addr,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [23:0] cart_addr,
  output logic        cart_cs,
  output logic        cart_rd,
  output logic        cart_wr,
  input  logic [15:0] cart_data_in,
  output logic [15:0] cart_data_out,
  output logic        cart_data_oe
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_SAMPLE,
    ST_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_ready;
  logic        w_busy;
  logic        w_rsp;
  logic        w_first_of_word;

  logic [3:0]  r_cnt;
  logic        r_write;
  logic        r_word;
  logic        r_half;
  logic [15:0] r_wdata_hi;
  logic [15:0] r_rd_lo;
  logic [23:0] r_cart_addr;
  logic [15:0] r_cart_dout;
  logic [31:0] r_rsp_rdata;

  // Byte lane select is meaningless on a 16-bit bus.
  logic        w_unused_addr0;
  assign w_unused_addr0 = req_addr[0];

  // A word access still has its second halfword to run.
  assign w_first_of_word = r_word && !r_half;

  // State register; reset forces IDLE so strobes drop immediately.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_rsp   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (req_valid) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_busy = 1'b1;
        w_next = (N_WAIT == 0) ? ST_SAMPLE : ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt <= 4'd1) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_busy = 1'b1;
        if (w_first_of_word) begin
          w_next = (S_WAIT == 0) ? ST_SAMPLE : ST_WAIT;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, halfword sequencing and read capture.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_word      <= 1'b0;
      r_half      <= 1'b0;
      r_wdata_hi  <= 16'd0;
      r_rd_lo     <= 16'd0;
      r_cart_addr <= 24'd0;
      r_cart_dout <= 16'd0;
      r_rsp_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_word      <= req_word;
            r_half      <= 1'b0;
            r_wdata_hi  <= req_wdata[31:16];
            r_cart_dout <= req_wdata[15:0];
            // Words are halfword-pair aligned; halves never carry.
            r_cart_addr <= {req_addr[24:2], req_word ? 1'b0 : req_addr[1]};
          end
        end
        ST_SETUP: begin
          r_cnt <= 4'(N_WAIT);
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        ST_SAMPLE: begin
          if (w_first_of_word) begin
            r_half         <= 1'b1;
            r_rd_lo        <= cart_data_in;
            r_cart_addr[0] <= 1'b1;
            r_cart_dout    <= r_wdata_hi;
            r_cnt          <= 4'(S_WAIT);
          end else if (!r_write) begin
            // Publish the whole result at once so rsp_rdata only changes
            // when a read completes.
            r_rsp_rdata <= r_word ? {cart_data_in, r_rd_lo} : {16'd0, cart_data_in};
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = w_ready;
  assign rsp_valid     = w_rsp;
  assign rsp_rdata     = r_rsp_rdata;
  assign cart_addr     = r_cart_addr;
  assign cart_cs       = w_busy;
  assign cart_rd       = w_busy && !r_write;
  assign cart_wr       = w_busy && r_write;
  assign cart_data_oe  = w_busy && r_write;
  assign cart_data_out = r_cart_dout;

endmodule

// File: tb/tb_gba_cart_bus_ctrl.sv
// Self-checking bench for gba_cart_bus_ctrl. Two instances run side by side:
// u[0] with N_WAIT=4/S_WAIT=2 and u[1] with N_WAIT=0/S_WAIT=0. Stimulus pushes
// expected transactions into a queue; a monitor per instance checks the
// cartridge bus every cycle and the response when rsp_valid appears.
`timescale 1ns/1ps
module tb_gba_cart_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          t;
    bit          w;
    bit          word;
    logic [24:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  task automatic check(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL u%0d %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  inst, nm, got, exp, cyc);
  endtask

  // Cartridge ROM contents: a few fixed words plus a scrambled fill.
  function automatic logic [15:0] cart_mem(input logic [23:0] a);
    if (a == 24'h000080) return 16'hBEEF;
    if (a == 24'h000100) return 16'h1234;
    if (a == 24'h000101) return 16'h5678;
    return 16'((a * 24'd40503) ^ (a >> 7) ^ 24'h00A5C3);
  endfunction

  // Halfword index of the first halfword: byte/2, or (byte/4)*2 for words.
  function automatic logic [23:0] base_addr(input logic [24:0] a, input bit word);
    if (word) return 24'((a / 4) * 2);
    return 24'(a / 2);
  endfunction

  function automatic int lat_of(input bit word, input int nw, input int sw);
    return word ? (4 + nw + sw) : (3 + nw);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NW     = (g == 0) ? 4 : 0;
    localparam int SW     = (g == 0) ? 2 : 0;
    localparam int RST_AT = (g == 0) ? 3 : 1;

    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [24:0] req_addr;
    logic        req_write;
    logic        req_word;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [23:0] cart_addr;
    logic        cart_cs;
    logic        cart_rd;
    logic        cart_wr;
    logic [15:0] cart_data_in;
    logic [15:0] cart_data_out;
    logic        cart_data_oe;

    txn_t        q[$];
    logic [31:0] last_rd = 32'd0;
    bit          done = 1'b0;
    int          prev_t = 0;
    int          prev_lat = 0;
    bit          prev_b2b = 1'b0;

    gba_cart_bus_ctrl #(.N_WAIT(NW), .S_WAIT(SW)) dut (
      .clk_74a      (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_write    (req_write),
      .req_word     (req_word),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .cart_addr    (cart_addr),
      .cart_cs      (cart_cs),
      .cart_rd      (cart_rd),
      .cart_wr      (cart_wr),
      .cart_data_in (cart_data_in),
      .cart_data_out(cart_data_out),
      .cart_data_oe (cart_data_oe)
    );

    assign cart_data_in = cart_rd ? cart_mem(cart_addr) : 16'hDEAD;

    // Present a request until accepted, record the expectation, then keep
    // scribbling on req_* while busy. rst_at>0 pulls reset_n in that cycle.
    task automatic issue(input bit w, input bit word, input logic [24:0] a,
                         input logic [31:0] wd, input int gap, input int rst_at);
      txn_t        e;
      int          n;
      int          lat;
      logic [23:0] ab;
      req_valid = 1'b1;
      req_write = w;
      req_word  = word;
      req_addr  = a;
      req_wdata = wd;
      n = 0;
      forever begin
        @(negedge clk);
        if (req_ready) break;
        n++;
        if (n > 1000) begin
          check("accept_timeout", g, 32'd0, 32'd1);
          $fatal(1, "bench stopped: request never accepted");
        end
      end
      lat = lat_of(word, NW, SW);
      ab  = base_addr(a, word);
      if (!w) begin
        last_rd = word ? {cart_mem(ab + 24'd1), cart_mem(ab)} : {16'd0, cart_mem(ab)};
      end
      e.t = cyc; e.w = w; e.word = word; e.a = a; e.wd = wd; e.rd = last_rd;
      q.push_back(e);
      if (prev_b2b) check("b2b_spacing", g, 32'(cyc - prev_t), 32'(prev_lat + 1));
      prev_t   = cyc;
      prev_lat = lat;
      prev_b2b = (gap == 0) && (rst_at == 0);
      for (int j = 1; j <= lat; j++) begin
        @(posedge clk);
        #1;
        if (j == rst_at) begin
          #2 reset_n = 1'b0;
          #1;
          check("rst_strobes", g, 32'({cart_cs, cart_rd, cart_wr, cart_data_oe}), 32'd0);
          check("rst_ready", g, 32'(req_ready), 32'd1);
          q.delete();
          last_rd   = 32'd0;
          prev_b2b  = 1'b0;
          req_valid = 1'b0;
          @(posedge clk);
          #1 reset_n = 1'b1;
          check("rst_rdata", g, rsp_rdata, 32'd0);
          return;
        end
        if (j < lat) begin
          req_valid = 1'($urandom);
          req_write = 1'($urandom);
          req_word  = 1'($urandom);
          req_addr  = 25'($urandom);
          req_wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Stimulus
    initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_word  = 1'b0;
      req_addr  = 25'd0;
      req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", g, 32'(req_ready), 32'd1);
      check("reset_rsp_valid", g, 32'(rsp_valid), 32'd0);
      check("reset_strobes", g, 32'({cart_cs, cart_rd, cart_wr, cart_data_oe}), 32'd0);
      check("reset_cart_addr", g, 32'(cart_addr), 32'd0);
      check("reset_data_out", g, 32'(cart_data_out), 32'd0);
      check("reset_rdata", g, rsp_rdata, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Halfword read of 0xBEEF at halfword 0x80
      issue(1'b0, 1'b0, 25'h0000100, 32'd0, 0, 0);
      check("t1_rdata", g, rsp_rdata, 32'h0000BEEF);
      // Word read across halfwords 0x100/0x101
      issue(1'b0, 1'b1, 25'h0000200, 32'd0, 0, 0);
      check("t2_rdata", g, rsp_rdata, 32'h56781234);
      // Word write leaves read data untouched
      issue(1'b1, 1'b1, 25'h0123456, 32'hCAFEF00D, 1, 0);
      check("t3_rdata_held", g, rsp_rdata, 32'h56781234);
      // Top of space, word with addr[1] set: halves 0xFFFFFE, 0xFFFFFF
      issue(1'b0, 1'b1, 25'h1FFFFFE, 32'd0, 1, 0);
      // Odd byte address on a halfword read
      issue(1'b0, 1'b0, 25'h0000101, 32'd0, 1, 0);
      check("odd_addr_rdata", g, rsp_rdata, 32'h0000BEEF);
      // Back-to-back word reads
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 25'($urandom), 32'd0, 0, 0);
      issue(1'b1, 1'b0, 25'($urandom), $urandom, 2, 0);
      // Reset in the middle of a read and of a word write
      issue(1'b0, 1'b0, 25'($urandom), 32'd0, 0, RST_AT);
      issue(1'b1, 1'b1, 25'($urandom), $urandom, 0, RST_AT);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 60; i++) begin
        issue(1'($urandom), 1'($urandom), 25'($urandom), $urandom,
              int'($urandom_range(0, 2)), 0);
      end
      repeat (3) @(posedge clk);
      done = 1'b1;
    end

    // Monitor: bus and response checks against the front of the queue.
    initial begin : mon
      txn_t        e;
      int          k;
      int          lat;
      logic [23:0] ab;
      bit          act;
      bit          h2;
      repeat (2) @(posedge clk);
      forever begin
        @(negedge clk);
        if (q.size() == 0) begin
          check("idle_bus", g, 32'({cart_cs, cart_rd, cart_wr, cart_data_oe}), 32'd0);
          check("idle_rsp", g, 32'(rsp_valid), 32'd0);
          check("idle_ready", g, 32'(req_ready), 32'd1);
        end else begin
          e   = q[0];
          k   = cyc - e.t;
          lat = lat_of(e.word, NW, SW);
          act = (k >= 1) && (k < lat);
          check("ready", g, 32'(req_ready), 32'(k == 0));
          check("cs", g, 32'(cart_cs), 32'(act));
          if (act) begin
            ab = base_addr(e.a, e.word);
            h2 = e.word && (k >= 3 + NW);
            check("rd", g, 32'(cart_rd), 32'(!e.w));
            check("wr", g, 32'(cart_wr), 32'(e.w));
            check("oe", g, 32'(cart_data_oe), 32'(e.w));
            check("addr", g, 32'(cart_addr), 32'(h2 ? ab + 24'd1 : ab));
            if (e.w) check("data_out", g, 32'(cart_data_out),
                           32'(h2 ? e.wd[31:16] : e.wd[15:0]));
          end else begin
            check("strobes_off", g, 32'({cart_rd, cart_wr, cart_data_oe}), 32'd0);
          end
          check("rsp_valid", g, 32'(rsp_valid), 32'(k == lat));
          if (k == lat) check("rdata", g, rsp_rdata, e.rd);
          if (k >= lat) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(u[0].done && u[1].done) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    check("run_complete", 9, 32'(u[0].done && u[1].done), 32'd1);
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
